// File: rtl/store_merge_rmw_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_merge_rmw_if
//  Description : Bus bundle for the store merge unit. Carries the CPU store
//                request/response signals and the word-wide single-port RAM
//                port. The slave modport is the merge unit itself; the master
//                modport is whatever drives requests and models the RAM.
//  Signals     : req, size[1:0], addr[31:0], wdata[31:0]    CPU -> unit
//                ready, done, err                            unit -> CPU
//                mem_addr[31:0], mem_rd, mem_we, mem_wdata   unit -> RAM
//                mem_rdata[31:0]                             RAM  -> unit
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_merge_rmw_if;
  logic        req;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  modport slave (
    input  req, size, addr, wdata, mem_rdata,
    output ready, done, err, mem_addr, mem_rd, mem_we, mem_wdata
  );

  modport master (
    output req, size, addr, wdata, mem_rdata,
    input  ready, done, err, mem_addr, mem_rd, mem_we, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/store_merge_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : store_merge_rmw
//  Description : Store-side byte/halfword merge. Sub-word stores become a
//                read-modify-write of one RAM word (the RAM has no byte
//                enables); word stores are written directly. Misaligned or
//                illegal-size stores finish with err and no memory write.
//  Ports       : clk_i    - clock, all state changes on the rising edge
//                rst_n_i  - synchronous active-low reset
//                bus      - store_merge_rmw_if.slave (request + RAM port)
//  Revision    : 1.0 - initial release
// ============================================================================
module store_merge_rmw (
  input  wire logic           clk_i,
  input  wire logic           rst_n_i,
  store_merge_rmw_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;

  logic        req_fault;
  logic [31:0] merge_word;

  // Alignment / legality of the incoming request.
  always_comb begin
    req_fault = 1'b0;
    case (bus.size)
      SZ_HALF: req_fault = bus.addr[0];
      SZ_WORD: req_fault = (bus.addr[1:0] != 2'b00);
      SZ_BYTE: req_fault = 1'b0;
      default: req_fault = 1'b1;
    endcase
  end

  // Read word with the addressed lane(s) replaced; lanes are little-endian.
  always_comb begin
    merge_word = bus.mem_rdata;
    if (size_q == SZ_BYTE) begin
      merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          size_d  = bus.size;
          wdata_d = bus.wdata;
          if (req_fault) begin
            state_d = S_FAULT;
          end else if (bus.size == SZ_WORD) begin
            merged_d = bus.wdata;
            state_d  = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_MERGE;
      S_MERGE: begin
        merged_d = merge_word;
        state_d  = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'd0;
      size_q   <= 2'b00;
      wdata_q  <= 32'd0;
      merged_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
    end
  end

  // Moore outputs.
  assign bus.ready     = (state_q == S_IDLE);
  assign bus.mem_rd    = (state_q == S_READ);
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.done      = (state_q == S_WRITE) || (state_q == S_FAULT);
  assign bus.err       = (state_q == S_FAULT);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = merged_q;

endmodule
`default_nettype wire
